// File: rtl/alert_reporter.sv
// alert_reporter: captures detector alert changes, timestamps them, queues
// them in a small FIFO and serializes each event as a 3-byte record
// ({1,prio,type,ovf}, bitmap, ts) over an 8-bit valid/ready stream.
// Optional feature macro: ALERT_RATE_LIMIT_EN enables a capture hold-off of
// HOLDOFF cycles after each successful push.
module alert_reporter #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alert_any,
  input  logic [2:0]               alert_priority,
  input  logic [2:0]               alert_type,
  input  logic [7:0]               alert_bitmap,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               dropped_cnt
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF < 1 || HOLDOFF > 255) begin : g_param_check
    $error("alert_reporter: DEPTH must be a power of 2 >= 2, HOLDOFF in 1..255");
  end

  typedef struct packed {
    logic [2:0] prio;
    logic [2:0] atype;
    logic [7:0] bitmap;
    logic [7:0] ts;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_B2} state_e;

  logic [7:0]    ts_q;
  logic [7:0]    last_cap_q;
  logic [7:0]    dropped_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          ovf_sh_q;
  rec_t          sh_q;
  rec_t          mem_q [DEPTH];
  state_e        state_q, state_d;

  logic cap, cap_gate, full, empty, pop, push, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // A capture is a change to a new non-zero bitmap while any detector is active.
  assign cap  = alert_any && (alert_bitmap != 8'h00) && (alert_bitmap != last_cap_q) && cap_gate;
  // A full FIFO still accepts the push when the serializer pops in the same cycle.
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

`ifdef ALERT_RATE_LIMIT_EN
  logic [7:0] holdoff_q;
  assign cap_gate = (holdoff_q == 8'h00);

  // Hold-off counter: reloads on each push so the next capture lands exactly
  // HOLDOFF cycles after this one (the push cycle itself counts as one).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  holdoff_q <= 8'h00;
    else if (push)               holdoff_q <= 8'(HOLDOFF - 1);
    else if (holdoff_q != 8'h00) holdoff_q <= holdoff_q - 8'd1;
  end
`else
  assign cap_gate = 1'b1;
`endif

  // Timestamp, change detector, drop counter and overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= 8'h00;
      last_cap_q <= 8'h00;
      dropped_q  <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      ts_q <= ts_q + 8'd1;
      if (!alert_any) last_cap_q <= 8'h00;
      else if (cap)   last_cap_q <= alert_bitmap;
      if (drop && dropped_q != 8'hFF) dropped_q <= dropped_q + 8'd1;
      // A drop in the same cycle as a pop keeps the flag set for the next record.
      if (drop)     ovf_q <= 1'b1;
      else if (pop) ovf_q <= 1'b0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage.
  // NOTE: the data array is deliberately not reset; occupancy is tracked by
  // count_q, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{prio: alert_priority, atype: alert_type,
                                   bitmap: alert_bitmap, ts: ts_q};
  end

  // Serializer state and shadow record being transmitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      ovf_sh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        sh_q     <= mem_q[rd_ptr_q];
        ovf_sh_q <= ovf_q;
      end
    end
  end

  // Serializer next state and pop decision; advances only on accepted bytes.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = S_B0;
      end
      S_B0: if (out_ready) state_d = S_B1;
      S_B1: if (out_ready) state_d = S_B2;
      S_B2: if (out_ready) begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_B0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output byte selected from the shadow record; held while the sink stalls.
  always_comb begin
    out_data = 8'h00;
    case (state_q)
      S_B0:    out_data = {1'b1, sh_q.prio, sh_q.atype, ovf_sh_q};
      S_B1:    out_data = sh_q.bitmap;
      S_B2:    out_data = sh_q.ts;
      default: out_data = 8'h00;
    endcase
  end

  assign out_valid   = (state_q != S_IDLE);
  assign fifo_count  = count_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_alert_reporter.sv
// Self-checking bench for alert_reporter: directed scenarios plus a randomized
// run scored against a queue-based event model.
module tb_alert_reporter;

  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alert_any = 1'b0;
  logic [2:0] alert_priority = 3'd0;
  logic [2:0] alert_type = 3'd0;
  logic [7:0] alert_bitmap = 8'h00;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [2:0] fifo_count;
  logic [7:0] dropped_cnt;

  always #5 clk = ~clk;

  alert_reporter #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alert_any      (alert_any),
    .alert_priority (alert_priority),
    .alert_type     (alert_type),
    .alert_bitmap   (alert_bitmap),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count),
    .dropped_cnt    (dropped_cnt)
  );

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  // Bytes the DUT actually handed over, and the edge at which each was accepted.
  logic [7:0] got[$];
  int         got_cyc[$];

  // Reference model: pending events, bytes still to send for the current record.
  typedef struct packed {
    logic [2:0] prio;
    logic [2:0] typ;
    logic [7:0] bm;
    logic [7:0] ts;
  } mrec_t;

  mrec_t      m_fifo[$];
  logic [7:0] m_ser[$];
  logic [7:0] m_exp[$];
  logic       m_ovf;
  int         m_drop;
  logic [7:0] m_ts;
  logic [7:0] m_last;
  int         m_since;

  task automatic model_reset();
    m_fifo.delete();
    m_ser.delete();
    m_exp.delete();
    m_ovf   = 1'b0;
    m_drop  = 0;
    m_ts    = 8'h00;
    m_last  = 8'h00;
    m_since = HOLDOFF;
  endtask

  // One clock edge of the event-level model, using the inputs present at the edge.
  task automatic model_step();
    bit    pop, cap, allowed;
    mrec_t h;
    logic [7:0] b0;
    if (m_ser.size() > 0 && out_ready) m_exp.push_back(m_ser.pop_front());
    if (m_since < HOLDOFF) m_since++;
`ifdef ALERT_RATE_LIMIT_EN
    allowed = (m_since >= HOLDOFF);
`else
    allowed = 1'b1;
`endif
    cap = alert_any && (alert_bitmap != 8'h00) && (alert_bitmap != m_last) && allowed;
    if (!alert_any) m_last = 8'h00;
    else if (cap)   m_last = alert_bitmap;
    pop = (m_ser.size() == 0) && (m_fifo.size() > 0);
    if (pop) begin
      h  = m_fifo.pop_front();
      b0 = {1'b1, h.prio, h.typ, m_ovf};
      m_ser.push_back(b0);
      m_ser.push_back(h.bm);
      m_ser.push_back(h.ts);
    end
    if (cap) begin
      if (m_fifo.size() < DEPTH) begin
        m_fifo.push_back('{prio: alert_priority, typ: alert_type, bm: alert_bitmap, ts: m_ts});
        m_since = 0;
        if (pop) m_ovf = 1'b0;
      end else begin
        m_drop++;
        m_ovf = 1'b1;
      end
    end else if (pop) begin
      m_ovf = 1'b0;
    end
    m_ts = m_ts + 8'd1;
  endtask

  // Advance one clock: record an accepted byte, step the model, return at negedge.
  task automatic run_cycle();
    logic       acc;
    logic [7:0] b;
    acc = out_valid && out_ready;
    b   = out_data;
    @(posedge clk);
    edge_n++;
    if (acc) begin
      got.push_back(b);
      got_cyc.push_back(edge_n);
    end
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    alert_any      = 1'b0;
    alert_bitmap   = 8'h00;
    alert_priority = 3'd0;
    alert_type     = 3'd0;
    repeat (2) @(negedge clk);
    model_reset();
    got.delete();
    got_cyc.delete();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] got_at(int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00)  begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (dropped_cnt !== 8'd0) begin failures++; $display("FAIL reset_dropped got=%0d exp=0", dropped_cnt); end
  endtask

  task automatic test_first_record();
    logic [7:0] e[3];
    int cap_edge;
    e = '{8'hFE, 8'h80, 8'h0A};
    do_reset();
    out_ready = 1'b1;
    while (m_ts != 8'd10) run_cycle();
    alert_any = 1'b1; alert_priority = 3'd7; alert_type = 3'd7; alert_bitmap = 8'h80;
    cap_edge = edge_n + 1;
    repeat (16) run_cycle();
    checks++; if (got.size() != 3) begin failures++; $display("FAIL first_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_at(i) !== e[i]) begin failures++; $display("FAIL first_byte%0d got=%h exp=%h", i, got_at(i), e[i]); end
      checks++;
      if (i >= got_cyc.size() || got_cyc[i] != cap_edge + 2 + i) begin
        failures++; $display("FAIL first_timing%0d exp_edge=%0d", i, cap_edge + 2 + i);
      end
    end
  endtask

  task automatic test_change_sequence();
    logic [7:0] seq[4];
    logic [7:0] e[9];
    logic [7:0] t0;
    seq = '{8'h01, 8'h03, 8'h03, 8'h02};
    do_reset();
    out_ready = 1'b1;
    repeat (3) run_cycle();
    alert_any = 1'b1; alert_priority = 3'd3; alert_type = 3'd5;
    t0 = m_ts;
    for (int i = 0; i < 4; i++) begin
      alert_bitmap = seq[i];
      run_cycle();
    end
    alert_any = 1'b0; alert_bitmap = 8'h00;
    repeat (15) run_cycle();
    e = '{8'hBA, 8'h01, t0, 8'hBA, 8'h03, t0 + 8'd1, 8'hBA, 8'h02, t0 + 8'd3};
    checks++; if (got.size() != 9) begin failures++; $display("FAIL seq_count got=%0d exp=9", got.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got_at(i) !== e[i]) begin failures++; $display("FAIL seq_byte%0d got=%h exp=%h", i, got_at(i), e[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    alert_any = 1'b1; alert_priority = 3'd2; alert_type = 3'd1;
    for (int i = 1; i <= 7; i++) begin
      alert_bitmap = 8'(i);
      run_cycle();
    end
    alert_any = 1'b0; alert_bitmap = 8'h00;
    run_cycle();
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    checks++; if (dropped_cnt !== 8'd2) begin failures++; $display("FAIL ovf_dropped got=%0d exp=2", dropped_cnt); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", out_valid); end
    out_ready = 1'b1;
    repeat (25) run_cycle();
    checks++; if (got.size() != 15) begin failures++; $display("FAIL ovf_records got=%0d exp=15", got.size()); end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (got_at(3*r)[0] !== (r == 1)) begin failures++; $display("FAIL ovf_flag%0d got=%b exp=%b", r, got_at(3*r)[0], (r == 1)); end
      checks++;
      if (got_at(3*r+1) !== 8'(r + 1)) begin failures++; $display("FAIL ovf_bitmap%0d got=%h exp=%h", r, got_at(3*r+1), 8'(r + 1)); end
    end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_toggle_and_wrap();
    do_reset();
    out_ready = 1'b1;
    alert_bitmap = 8'h04;
    alert_any = 1'b1; run_cycle();
    alert_any = 1'b0; run_cycle();
    alert_any = 1'b1; run_cycle();
    alert_any = 1'b0; alert_bitmap = 8'h00;
    repeat (12) run_cycle();
    checks++; if (got.size() != 6) begin failures++; $display("FAIL toggle_count got=%0d exp=6", got.size()); end
    checks++; if (got_at(1) !== 8'h04 || got_at(4) !== 8'h04) begin
      failures++; $display("FAIL toggle_bitmap got=%h,%h exp=04,04", got_at(1), got_at(4));
    end
    while (m_ts != 8'hFF) run_cycle();
    got.delete(); got_cyc.delete();
    alert_any = 1'b1; alert_bitmap = 8'h11; run_cycle();
    alert_bitmap = 8'h22; run_cycle();
    alert_any = 1'b0; alert_bitmap = 8'h00;
    repeat (12) run_cycle();
    checks++; if (got.size() != 6) begin failures++; $display("FAIL wrap_count got=%0d exp=6", got.size()); end
    checks++; if (got_at(2) !== 8'hFF) begin failures++; $display("FAIL wrap_ts255 got=%h exp=ff", got_at(2)); end
    checks++; if (got_at(5) !== 8'h00) begin failures++; $display("FAIL wrap_ts0 got=%h exp=00", got_at(5)); end
  endtask

  task automatic test_reset_mid_record();
    int budget;
    do_reset();
    out_ready = 1'b0;
    alert_any = 1'b1; alert_priority = 3'd5; alert_type = 3'd2;
    for (int i = 1; i <= 7; i++) begin
      alert_bitmap = 8'(8'h10 + i);
      run_cycle();
    end
    alert_any = 1'b0; alert_bitmap = 8'h00;
    out_ready = 1'b1;
    budget = 0;
    while (got.size() < 2 && budget < 50) begin
      run_cycle();
      budget++;
    end
    checks++; if (got.size() != 2) begin failures++; $display("FAIL midrst_wait got=%0d exp=2", got.size()); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_count !== 3'd0)  begin failures++; $display("FAIL midrst_count got=%0d exp=0", fifo_count); end
    checks++; if (dropped_cnt !== 8'd0) begin failures++; $display("FAIL midrst_dropped got=%0d exp=0", dropped_cnt); end
    do_reset();
    repeat (20) run_cycle();
    checks++; if (got.size() != 0) begin failures++; $display("FAIL midrst_resend got=%0d exp=0", got.size()); end
  endtask

`ifdef ALERT_RATE_LIMIT_EN
  task automatic test_rate_limit();
    logic [7:0] t0;
    do_reset();
    out_ready = 1'b1;
    repeat (2) run_cycle();
    alert_any = 1'b1; alert_priority = 3'd4; alert_type = 3'd4;
    t0 = m_ts;
    for (int i = 0; i < 40; i++) begin
      alert_bitmap = 8'(i + 1);
      run_cycle();
    end
    alert_any = 1'b0; alert_bitmap = 8'h00;
    repeat (12) run_cycle();
    checks++; if (got.size() != 9) begin failures++; $display("FAIL rl_count got=%0d exp=9", got.size()); end
    for (int r = 0; r < 3; r++) begin
      checks++;
      if (got_at(3*r+1) !== 8'(16*r + 1)) begin failures++; $display("FAIL rl_bitmap%0d got=%h exp=%h", r, got_at(3*r+1), 8'(16*r + 1)); end
      checks++;
      if (got_at(3*r+2) !== t0 + 8'(16*r)) begin failures++; $display("FAIL rl_ts%0d got=%h exp=%h", r, got_at(3*r+2), t0 + 8'(16*r)); end
    end
    checks++; if (dropped_cnt !== 8'd0) begin failures++; $display("FAIL rl_dropped got=%0d exp=0", dropped_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] pick[5];
    logic [7:0] exp_drop;
    pick = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80};
    do_reset();
    for (int i = 0; i < 600; i++) begin
      alert_any      = ($urandom_range(0, 9) < 8);
      alert_bitmap   = ($urandom_range(0, 5) == 5) ? 8'($urandom) : pick[$urandom_range(0, 4)];
      alert_priority = 3'($urandom);
      alert_type     = 3'($urandom);
      out_ready      = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      run_cycle();
      exp_drop = (m_drop > 255) ? 8'hFF : 8'(m_drop);
      checks++;
      if (fifo_count !== 3'(m_fifo.size())) begin failures++; $display("FAIL rnd_count@%0d got=%0d exp=%0d", i, fifo_count, m_fifo.size()); end
      checks++;
      if (dropped_cnt !== exp_drop) begin failures++; $display("FAIL rnd_dropped@%0d got=%0d exp=%0d", i, dropped_cnt, exp_drop); end
      checks++;
      if (out_valid !== (m_ser.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d got=%b exp=%b", i, out_valid, (m_ser.size() > 0)); end
      if (m_ser.size() > 0) begin
        checks++;
        if (out_data !== m_ser[0]) begin failures++; $display("FAIL rnd_data@%0d got=%h exp=%h", i, out_data, m_ser[0]); end
      end
      checks++;
      if (got.size() != m_exp.size() || (got.size() > 0 && got[got.size()-1] !== m_exp[m_exp.size()-1])) begin
        failures++; $display("FAIL rnd_stream@%0d got_n=%0d exp_n=%0d", i, got.size(), m_exp.size());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_record();
`ifndef ALERT_RATE_LIMIT_EN
    test_change_sequence();
    test_overflow();
    test_toggle_and_wrap();
`else
    test_rate_limit();
`endif
    test_reset_mid_record();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
